sync_fifo_fwft: RTL
===================

Name: sync_fifo_fwft

Overview:
Single-clock, first-word-fall-through FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It is the same-domain companion to the dual-clock FIFO and buffers streams between pipeline stages sharing one clock. It keeps the wput/rget/full/empty handshake, and adds full-plus-read pass-through plus the status outputs.

Parameters:
WIDTH, 8, data width in bits (>=1)
ENTRIES, 16, storage depth; power of 2, >=2
AFULL_LVL, ENTRIES-2, almost_full asserts when count >= AFULL_LVL (1..ENTRIES)
AEMPTY_LVL, 2, almost_empty asserts when count <= AEMPTY_LVL (0..ENTRIES-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of contents and pointers
din  in  WIDTH  write data
wput  in  1  write request
full  out  1  1 = count == ENTRIES
almost_full  out  1  count >= AFULL_LVL
dout  out  WIDTH  head entry, valid whenever empty == 0
rget  in  1  pop head entry
empty  out  1  1 = count == 0
almost_empty  out  1  count <= AEMPTY_LVL
count  out  $clog2(ENTRIES)+1  current occupancy, 0..ENTRIES
overflow  out  1  sticky: write attempted and rejected
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Storage: ENTRIES x WIDTH register array. wr_ptr and rd_ptr are ADDR_SIZE = $clog2(ENTRIES) bits wide and wrap naturally. count is a separate registered counter.
- Reset (rst = 1, asynchronous): wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0. Outputs: empty = 1, full = 0, almost_empty = 1, almost_full = (AFULL_LVL == 0 ? 1 : 0) (never, given the legal range). Memory contents are not reset.
- dout = mem[rd_ptr], combinational from registered state. When empty == 1, dout is don't-care and the bench must not check it.
- Write acceptance: wr_acc = wput & ~flush & (~full | rget_acc). On wr_acc, mem[wr_ptr] <= din and wr_ptr increments.
- Read acceptance: rget_acc = rget & ~empty & ~flush. On rget_acc, rd_ptr increments.
- Full with simultaneous rget: both operations are accepted and count stays at ENTRIES.
- Empty with simultaneous wput: only the write is accepted; rget is an underflow. There is no same-cycle bypass of din to dout.
- count_next = count + wr_acc - rget_acc. All flags are decoded from the registered count, so they are valid in the cycle after the event causing them.
- Latency: a write accepted in cycle N is visible on dout with empty = 0 in cycle N+1. A pop in cycle N presents the next entry on dout in cycle N+1.
- overflow is set when wput & ~flush & full & ~rget_acc. underflow is set when rget & empty & ~flush. Both flags are sticky until rst or flush. Rejected operations leave pointers, memory and count unchanged.
- flush (synchronous, highest priority after rst): next cycle wr_ptr = rd_ptr = 0, count = 0, empty = 1, and both error flags are cleared. wput/rget in the flush cycle are ignored and do not set error flags.
- Reset mid-operation: rst wins immediately and asynchronously. Any write in progress is discarded.
- Thresholds: almost_full and almost_empty may be asserted together when the thresholds overlap; this is legal.
- Parameter checks: elaboration error if ENTRIES is not a power of 2, or if AFULL_LVL or AEMPTY_LVL is out of range.

Test Plan:
1. Reset, then write 0x11,0x22,0x33 on consecutive cycles, no rget -> count 1,2,3 on following cycles; empty drops 1 cycle after first write; dout = 0x11. Then pop 3 times -> dout 0x22, 0x33, then empty = 1, count = 0, underflow = 0.
2. Fill with 16 writes (defaults) -> full = 1 when count = 16; almost_full first seen when count = 14. A 17th wput (0xEE) -> overflow = 1, count stays 16, and draining returns the original 16 values in order.
3. Full, then wput = 1 and rget = 1 with din = 0xAB -> count stays 16, overflow stays 0, and 0xAB emerges as the 16th item after the pop.
4. Empty, then rget = 1 together with wput = 1 and din = 0x5A -> underflow = 1, count = 1, dout = 0x5A next cycle.
5. Write 40 items while popping continuously (pointer wrap, 2.5 laps) -> output sequence equals input sequence; count never exceeds 2; almost_empty stays 1.
6. With 5 entries stored and overflow set, assert flush with wput = 1 -> next cycle count = 0, empty = 1, overflow = 0. Then assert rst asynchronously between clock edges mid-burst -> all outputs take reset values before the next edge.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_fwft #(
    parameter int WIDTH      = 8,
    parameter int ENTRIES    = 16,
    parameter int AFULL_LVL  = ENTRIES - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    input  logic                       wput,
    output logic                       full,
    output logic                       almost_full,
    output logic [WIDTH-1:0]           dout,
    input  logic                       rget,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(ENTRIES):0]   count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int ADDR_SIZE = $clog2(ENTRIES);
    localparam int CW        = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("sync_fifo_fwft: ENTRIES must be a power of 2 and >= 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > ENTRIES) begin : g_bad_afull
        $error("sync_fifo_fwft: AFULL_LVL out of range 1..ENTRIES");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > ENTRIES - 1) begin : g_bad_aempty
        $error("sync_fifo_fwft: AEMPTY_LVL out of range 0..ENTRIES-1");
    end

    logic [WIDTH-1:0]     mem [ENTRIES];
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic                 wr_acc, rget_acc;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a write.
    assign rget_acc = rget & ~empty & ~flush;
    assign wr_acc   = wput & ~flush & (~full | rget_acc);

    assign full         = (count == CW'(ENTRIES));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_LVL));
    assign almost_empty = (count <= CW'(AEMPTY_LVL));
    assign dout         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)   wr_ptr <= wr_ptr + PTR_ONE;
            if (rget_acc) rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + CW'(wr_acc) - CW'(rget_acc);
            if (wput & full & ~rget_acc) overflow  <= 1'b1;
            if (rget & empty)            underflow <= 1'b1;
        end
    end
endmodule
